// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the boot-time instruction-memory loader:
//   loader_state_e    : loader FSM states
//   DEFAULT_SYNC_BYTE : frame-start byte used when the top is not overridden
//   COUNT_W           : width of the word count carried in the frame header
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_LO = 3'd1,
        S_CNT_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CHK    = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } loader_state_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         COUNT_W           = 16;

endpackage

// File: rtl/imem_byte_packer.sv
// -----------------------------------------------------------------------------
// imem_byte_packer
// Packs a little-endian byte stream into 32-bit words. The first byte of a
// word ends up in bits [7:0].
// Ports:
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_clear         : restart at byte index 0 (new frame)
//   i_shift         : accept i_byte this cycle
//   i_byte          : incoming byte
//   o_word_ready    : high in the cycle the 4th byte of a word is accepted
//   o_word          : completed word, valid while o_word_ready is high
// -----------------------------------------------------------------------------
module imem_byte_packer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic        o_word_ready,
    output logic [31:0] o_word
);

    // Only three bytes need storage: the 4th is taken straight from i_byte,
    // so the completed word is available in the cycle it arrives.
    logic [23:0] r_bytes;
    logic [1:0]  r_idx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bytes <= '0;
            r_idx   <= '0;
        end else if (i_clear) begin
            r_idx   <= '0;
        end else if (i_shift) begin
            r_bytes <= {i_byte, r_bytes[23:8]};
            r_idx   <= r_idx + 2'd1;
        end
    end

    assign o_word_ready = i_shift && (r_idx == 2'd3);
    assign o_word       = {i_byte, r_bytes};

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot-time instruction-memory writer. Frames the UART byte stream
//   SYNC, COUNT_LO, COUNT_HI, N x 4 data bytes (LSB first) [, CHK]
// into 32-bit words, writes them to the instruction memory and holds the CPU
// while loading.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing CHK byte
// that must equal the 8-bit sum of all data bytes.
// Ports:
//   i_clk, i_rst_n    : clock, asynchronous active-low reset
//   i_rx_data         : byte from the UART receiver
//   i_rx_valid        : one-cycle strobe, i_rx_data valid
//   o_imem_we         : registered one-cycle write enable
//   o_imem_waddr      : word address of the write
//   o_imem_wdata      : instruction word of the write
//   o_cpu_hold        : core held in reset while loading / after an abort
//   o_done            : last image loaded successfully
//   o_error           : last frame aborted
//   o_loaded_words    : words written in the current or last frame
//   o_state           : current loader state (debug)
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W    = 15,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_waddr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_error,
    output logic [ADDR_W:0]   o_loaded_words,
    output logic [2:0]        o_state
);

    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_e END_STATE = S_CHK;
`else
    localparam loader_state_e END_STATE = S_DONE;
`endif

    loader_state_e        r_state;
    loader_state_e        w_next_state;
    logic [COUNT_W-1:0]   r_count;
    logic [COUNT_W-1:0]   w_count_full;
    logic [ADDR_W:0]      r_loaded;
    logic [ADDR_W:0]      w_loaded_inc;
    logic                 w_start;
    logic                 w_shift;
    logic                 w_word_ready;
    logic [31:0]          w_word;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_waddr;
    logic [31:0]          r_wdata;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]           r_chk;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chk <= '0;
        end else if (w_start) begin
            r_chk <= '0;
        end else if (w_shift) begin
            r_chk <= r_chk + i_rx_data;
        end
    end
`endif

    imem_byte_packer u_packer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (w_start),
        .i_shift      (w_shift),
        .i_byte       (i_rx_data),
        .o_word_ready (w_word_ready),
        .o_word       (w_word)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_shift      = 1'b0;
        // Count as it will be once COUNT_HI is captured; used for the checks
        // made while leaving CNT_HI.
        w_count_full = {i_rx_data, r_count[7:0]};
        w_loaded_inc = r_loaded + (ADDR_W+1)'(1);
        unique case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
                    w_next_state = S_CNT_LO;
                    w_start      = 1'b1;
                end
            end
            S_CNT_LO: begin
                if (i_rx_valid) w_next_state = S_CNT_HI;
            end
            S_CNT_HI: begin
                if (i_rx_valid) begin
                    if (32'(w_count_full) > MAX_WORDS)  w_next_state = S_ERR;
                    else if (w_count_full == '0)        w_next_state = END_STATE;
                    else                                w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (i_rx_valid) begin
                    w_shift = 1'b1;
                    if (w_word_ready && (32'(w_loaded_inc) == 32'(r_count)))
                        w_next_state = END_STATE;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (i_rx_valid)
                    w_next_state = (i_rx_data == r_chk) ? S_DONE : S_ERR;
            end
`endif
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count  <= '0;
            r_loaded <= '0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_start) begin
                r_count  <= '0;
                r_loaded <= '0;
            end
            if ((r_state == S_CNT_LO) && i_rx_valid) r_count[7:0]  <= i_rx_data;
            if ((r_state == S_CNT_HI) && i_rx_valid) r_count[15:8] <= i_rx_data;
            // Write at the pre-increment count, then advance it.
            if (w_word_ready) begin
                r_we     <= 1'b1;
                r_waddr  <= r_loaded[ADDR_W-1:0];
                r_wdata  <= w_word;
                r_loaded <= w_loaded_inc;
            end
        end
    end

    assign o_imem_we      = r_we;
    assign o_imem_waddr   = r_waddr;
    assign o_imem_wdata   = r_wdata;
    assign o_loaded_words = r_loaded;
    assign o_state        = r_state;
    // ERR keeps the core held: a partial image must never run.
    assign o_cpu_hold     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done         = (r_state == S_DONE);
    assign o_error        = (r_state == S_ERR);

endmodule
